// File: rtl/johnson_seq_ctrl.sv
// Johnson-counter sequencer: runs a latched number of forward or reverse shifts
// with pause/abort control, a one-cycle completion pulse and a wrap-around flag.
module johnson_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          hold,
  input  logic                          dir,
  input  logic [CNT_W-1:0]              steps,
  input  logic                          clr,
  output logic [WIDTH-1:0]              jc_q,
  output logic [$clog2(2*WIDTH)-1:0]    phase,
  output logic                          busy,
  output logic                          done,
  output logic                          wrap
);

  localparam int PW = $clog2(2*WIDTH);
  localparam logic [PW-1:0] PHASE_MAX = PW'(2*WIDTH-1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] remaining, remaining_next;
  logic             dir_lat, dir_next;
  logic [WIDTH-1:0] jc_next, jc_fwd, jc_rev;
  logic [PW-1:0]    phase_next, phase_fwd, phase_rev;
  logic             wrap_next;
  logic             shift_en;

  // Reverse step is the exact inverse of the forward step, so phase tracks jc_q both ways.
  assign jc_fwd    = {jc_q[WIDTH-2:0], ~jc_q[WIDTH-1]};
  assign jc_rev    = {~jc_q[0], jc_q[WIDTH-1:1]};
  assign phase_fwd = (phase == PHASE_MAX) ? '0 : phase + 1'b1;
  assign phase_rev = (phase == '0) ? PHASE_MAX : phase - 1'b1;

  assign busy = (state == RUN) || (state == PAUSE);
  assign done = (state == DONE);

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    dir_next       = dir_lat;
    jc_next        = jc_q;
    phase_next     = phase;
    shift_en       = 1'b0;
    wrap_next      = 1'b0;

    case (state)
      IDLE: begin
        if (clr) begin
          jc_next    = '0;
          phase_next = '0;
        end
        if (start) begin
          if (steps != '0) begin
            state_next     = RUN;
            remaining_next = steps;
            dir_next       = dir;
          end else begin
            state_next = DONE;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (hold) begin
          state_next = PAUSE;
        end else begin
          shift_en = 1'b1;
          if (remaining == CNT_W'(1)) begin
            state_next = DONE;
          end
        end
      end
      PAUSE: begin
        if (stop) begin
          state_next = IDLE;
        end else if (!hold) begin
          state_next = RUN;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (shift_en) begin
      jc_next        = dir_lat ? jc_fwd : jc_rev;
      phase_next     = dir_lat ? phase_fwd : phase_rev;
      remaining_next = remaining - 1'b1;
      wrap_next      = dir_lat ? (phase == PHASE_MAX) : (phase == '0);
    end
  end

  // Reset input is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      dir_lat   <= 1'b0;
      jc_q      <= '0;
      phase     <= '0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      dir_lat   <= dir_next;
      jc_q      <= jc_next;
      phase     <= phase_next;
      wrap      <= wrap_next;
    end
  end

endmodule

// File: doc/johnson_seq_ctrl.md
JOHNSON_SEQ_CTRL -- requirements
Module: johnson_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning Johnson register width (2*WIDTH phases).
REQ-002 SHALL have parameter CNT_W, default 8, meaning step-count width.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  begin a run of `steps` shifts; sampled only in IDLE.
REQ-006 SHALL have port stop  input  1  abort the current run.
REQ-007 SHALL have port hold  input  1  freeze shifting while high.
REQ-008 SHALL have port dir  input  1  direction, 1=forward, 0=reverse; latched at start.
REQ-009 SHALL have port steps  input  CNT_W  number of shifts to perform; latched at start.
REQ-010 SHALL have port clr  input  1  load jc_q=0 and phase=0; honoured in IDLE only.
REQ-011 SHALL have port jc_q  output  WIDTH  Johnson counter register.
REQ-012 SHALL have port phase  output  $clog2(2*WIDTH)  registered phase index, 0..2*WIDTH-1.
REQ-013 SHALL have port busy  output  1  high in RUN or PAUSE.
REQ-014 SHALL have port done  output  1  one-cycle pulse on run completion.
REQ-015 SHALL have port wrap  output  1  one-cycle pulse on phase wrap-around.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, PAUSE, DONE.
REQ-017 Forward shift SHALL be jc_q_next = {jc_q[WIDTH-2:0], ~jc_q[WIDTH-1]}, phase +1 mod 2*WIDTH.
REQ-018 Reverse shift SHALL be jc_q_next = {~jc_q[0], jc_q[WIDTH-1:1]}, phase -1 mod 2*WIDTH (exact inverse of forward).
REQ-019 IDLE: start with steps!=0 SHALL go to RUN, latch remaining=steps and dir; no shift on that edge.
REQ-020 IDLE: start with steps==0 SHALL go to DONE with no shift.
REQ-021 IDLE: clr with start SHALL zero jc_q/phase and take the start in the same edge.
REQ-022 RUN priority SHALL be stop > hold > shift; start, clr, dir, steps ignored outside IDLE.
REQ-023 RUN, stop=1: SHALL go to IDLE, no shift, no done; jc_q/phase retained.
REQ-024 RUN, hold=1: SHALL go to PAUSE with no shift that edge.
REQ-025 RUN, otherwise: SHALL shift once, remaining-1; if remaining was 1 go to DONE.
REQ-026 PAUSE: stop SHALL go to IDLE; hold=0 SHALL go to RUN (no shift on that edge); else stay.
REQ-027 DONE SHALL last exactly one cycle with done=1, then IDLE.
REQ-028 Total shifts per uninterrupted run SHALL equal latched steps regardless of hold cycles.
REQ-029 wrap SHALL be registered, high the cycle after a shift taking phase 2*WIDTH-1->0 (forward) or 0->2*WIDTH-1 (reverse).
REQ-030 jc_q SHALL only ever hold the 2*WIDTH valid Johnson patterns; phase SHALL always match jc_q.

Reset
REQ-031 rst_n=1 SHALL immediately force IDLE, jc_q=0, phase=0, remaining=0, busy=0, done=0, wrap=0, including mid-run.
REQ-032 First rising clk after rst_n falls SHALL behave as IDLE.

Verification
REQ-033 Reset: rst_n=1 -> jc_q=8'h00, phase=0, busy=0, done=0, wrap=0.
REQ-034 From 00, start, steps=3, dir=1 -> jc_q 01,03,07 on successive edges, busy 3 cycles, done one cycle after, phase=3.
REQ-035 From 00, steps=16, dir=1 -> jc_q passes FF at phase 8, returns 00; wrap=1 exactly once, in the cycle jc_q returns to 00; done follows.
REQ-036 From 00, steps=1, dir=0 -> jc_q=8'h80, phase=15, wrap=1; then steps=1, dir=1 -> jc_q=00, phase=0, wrap=1.
REQ-037 steps=5 with hold high 2 cycles after 2nd shift -> jc_q frozen at 03, busy=1, run ends at 1F with done; stop at 07 in another run -> IDLE, no done, jc_q=07.
REQ-038 rst_n asserted mid-RUN at jc_q=0F -> outputs zero asynchronously; start, steps=0 afterward -> done pulse, jc_q=00.
